// File: rtl/normalizer32_pkg.sv
// normalizer32_pkg: shared constants and FSM encoding for normalizer32.
//   OP_W          operand / result width
//   CNT_W         shift-count width
//   MODE_UNSIGNED normalize until bit31 = 1
//   MODE_SIGNED   normalize until bit31 != bit30
package normalizer32_pkg;

    localparam int unsigned OP_W  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/normalizer32.sv
// normalizer32: iterative left-normalizer, one shift per clock.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       request, sampled only in IDLE (captures a and mode)
//   mode        0 = unsigned normalize, 1 = signed normalize
//   a           operand
//   busy        high while shifting
//   done        one-cycle pulse, result/count/zero valid
//   result      operand shifted left by count, zero-filled
//   count       number of shifts applied
//   zero        operand cannot be normalized (all-zero, or all-one in signed mode)
module normalizer32
    import normalizer32_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [OP_W-1:0]   a,
    output logic              busy,
    output logic              done,
    output logic [OP_W-1:0]   result,
    output logic [CNT_W-1:0]  count,
    output logic              zero
);

    state_t             state_q, state_d;
    logic [OP_W-1:0]    work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [OP_W-1:0]    result_q, result_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               zero_q, zero_d;

    logic               is_degen_c;
    logic               is_norm_c;

    // Termination tests on the working register
    assign is_degen_c = (work_q == '0) || ((mode_q == MODE_SIGNED) && (work_q == '1));
    assign is_norm_c  = (mode_q == MODE_SIGNED) ? (work_q[OP_W-1] ^ work_q[OP_W-2])
                                                : work_q[OP_W-1];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            mode_q   <= MODE_UNSIGNED;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            count_q  <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            count_q  <= count_d;
            zero_q   <= zero_d;
        end
    end

    // Next-state and output logic; outputs only change when an operation completes
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        count_d  = count_q;
        zero_d   = zero_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = a;
                    mode_d  = mode;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (is_degen_c) begin
                    result_d = work_q;
                    count_d  = '0;
                    zero_d   = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else if (is_norm_c) begin
                    result_d = work_q;
                    count_d  = cnt_q;
                    zero_d   = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    // Non-degenerate operands normalize by 31 shifts, so cnt never wraps
                    work_d = {work_q[OP_W-2:0], 1'b0};
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign count  = count_q;
    assign zero   = zero_q;

endmodule

// File: doc/normalizer32.md
NORMALIZER32 -- requirements
Module: normalizer32

Interface
REQ-001 clk  input  1  single clock; all state changes on the rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request pulse; sampled only while idle.
REQ-004 mode  input  1  0 = unsigned normalize (until bit31=1); 1 = signed normalize (until bit31!=bit30).
REQ-005 a  input  32  operand; captured on the edge that accepts start.
REQ-006 busy  output  1  high from the accepting edge until done is asserted.
REQ-007 done  output  1  one-cycle pulse; result, count and zero are valid.
REQ-008 result  output  32  normalized operand (a shifted left by count, zero-filled).
REQ-009 count  output  5  number of left shifts applied, 0..31.
REQ-010 zero  output  1  operand cannot be normalized (mode 0: a=0; mode 1: a=0 or a=0xFFFFFFFF).

Function
REQ-011 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1, the block SHALL capture a and mode, clear the internal count, and enter SHIFT on that edge.
REQ-013 The block SHALL ignore start while in SHIFT or DONE: no recapture and no restart.
REQ-014 In SHIFT, if the operand is degenerate, it SHALL set zero=1, leave the operand unshifted, set count=0, and enter DONE.
REQ-015 In SHIFT, if the operand is normalized for the captured mode, it SHALL enter DONE without shifting.
REQ-016 Otherwise SHIFT SHALL shift the operand left by one bit, zero-filled, increment count by 1, and stay in SHIFT.
REQ-017 Latency: for a shift amount n, done SHALL be high in the cycle after edge n+1, counted from the accepting edge (edge 0).
REQ-018 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-019 A start accepted in that following IDLE cycle SHALL be legal, giving back-to-back operation.
REQ-020 result, count and zero SHALL be registered.
REQ-021 result, count and zero SHALL hold their values after done until the next accepted start updates them.
REQ-022 busy SHALL be high in SHIFT and low in IDLE and DONE.
REQ-023 count SHALL never exceed 31 in mode 0 nor 30 in mode 1.
REQ-024 The 5-bit count SHALL never wrap.
REQ-025 Mode is sampled only at start; changing mode mid-operation SHALL have no effect.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state=IDLE, busy=0, done=0, result=0, count=0 and zero=0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-028 After reset release, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the operand width constant (32), the count width (5) and the MODE_UNSIGNED/MODE_SIGNED constants.
REQ-030 The block SHALL be a single module with no sub-module.
REQ-031 Normalized and degenerate detection SHALL be combinational logic on the working register.

Verification
REQ-032 Bench SHALL cover: mode 0, a=0x00010000 -> done after edge 16, result=0x80000000, count=15, zero=0.
REQ-033 Bench SHALL cover: mode 0, a=0x00000001 -> count=31, result=0x80000000; mode 0, a=0x80000000 -> count=0, done after edge 1.
REQ-034 Bench SHALL cover: mode 1, a=0xFFFFFFFE -> count=30, result=0x80000000; mode 1, a=0x00000001 -> count=30, result=0x40000000.
REQ-035 Bench SHALL cover: mode 0, a=0 and mode 1, a=0xFFFFFFFF -> zero=1, count=0, result=a, done after edge 1.
REQ-036 Bench SHALL cover: start re-pulsed with a different a while busy -> ignored, original result returned; then a new start in the IDLE cycle after done -> accepted.
REQ-037 Bench SHALL cover: rst_n pulled low mid-SHIFT at count=5 -> outputs zero immediately, no done pulse, and the next start gives a correct result.
